id_stage_decode: RTL and testbench
==================================

Name: id_stage_decode

Overview:
- Pipeline stage directly upstream of the immediate extender.
- Accepts fetched 32-bit instructions with a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Decodes the opcode into the 4-bit immediate-source selector, the raw 26-bit immediate field and register indices, and presents all of it registered to the execute-side consumer.
- Supports flush from branch resolution.

Parameters:
- PC_W, 32, width of program-counter passthrough.
- INSTR_W, 32, instruction width; fixed at 32, any other value is unsupported.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  discard all buffered instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  consumer accepts
- out_pc  out  PC_W  passthrough PC
- out_imm_in  out  26  in_instr[25:0], to immediate extender
- out_imm_src  out  4  immediate selector
- out_uses_imm  out  1  operand B is immediate
- out_rd, out_rs1, out_rs2  out  5 each  instr[25:21], [20:16], [15:11]
- out_illegal  out  1  present only with optional feature

Behaviour:
- Reset, asynchronous, active-low:
  - both buffer entries invalid; out_valid=0; in_ready=1.
  - all out_* data fields = 0.
- Decode, combinational on capture; stored registered:
  - opcode = instr[31:26]; class = opcode[5:3]; u = opcode[0].
  - Class mapping:
    - 000 A (reg-reg): imm_src=0000, uses_imm=0
    - 001 B and 101 F: imm_src={3'b000,u}
    - 010 C: {3'b010,u}
    - 110 G: {3'b100,u}
    - 011 D-lower: {3'b110,u}
    - 100 D-upper: 4'b0010 (default path of extender, upper placement)
    - 111 illegal: see Optional Feature
  - uses_imm=1 for every class except A and illegal.
- Buffer: main register (drives outputs) plus skid register.
  - in_ready = ~skid_valid, registered, no combinational path from out_ready.
  - Accept when in_valid & in_ready; deliver when out_valid & out_ready.
  - Accept, main empty or delivering this cycle → decoded word into main.
  - Accept, main full and not delivering → word into skid.
  - Deliver with skid full → skid moves to main; in_ready rises next cycle.
  - Simultaneous accept and deliver, skid empty → main replaced, out_valid stays 1 (full throughput, 1 instr/cycle).
- Latency: accepted instruction appears on out_* the next cycle when the stage is empty.
- Order strictly preserved; no instruction is dropped or duplicated absent flush.
- Flush:
  - Synchronous; next cycle both entries invalid, out_valid=0, in_ready=1.
  - A word offered in the flush cycle is discarded even if in_ready=1.
  - Flush overrides a simultaneous deliver; the consumer must ignore that handshake.
- Data fields hold their last value when out_valid=0; the consumer must not sample them.
- Reset mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- Macro: ID_STAGE_ILLEGAL_TRAP_EN.
- Defined:
  - out_illegal port exists.
  - Class 111 is delivered with out_illegal=1, imm_src=0000, uses_imm=0, register fields decoded normally.
  - out_illegal=0 for all other classes; reset value 0.
- Undefined:
  - port absent.
  - Class 111 is decoded exactly as class A (reg-reg nop-like behaviour), with no indication.

Test Plan:
- Reset then single instr 0x08000001 (class B, u=0... opcode 000010 → class 000? use 0x24001234 = opcode 001001), out_ready=1 → one cycle later out_valid=1, imm_src=0001, uses_imm=1, out_imm_in=0x0001234.
- Streaming 8 back-to-back instructions with out_ready=1 → 8 consecutive out_valid cycles, in_ready stays 1, PCs in order.
- Backpressure: out_ready=0 while 3 instrs offered → first two accepted (main+skid), in_ready=0 on the third. Release out_ready → all three delivered in order, no loss.
- Flush with main and skid full, in_valid=1 same cycle → next cycle out_valid=0, in_ready=1, offered word never appears.
- D-upper opcode 100000 → imm_src=0010. D-lower with u=1 (opcode 011001) → imm_src=1101. Class G, u=0 → imm_src=1000.
- Opcode 111000 → with ID_STAGE_ILLEGAL_TRAP_EN: out_illegal=1, uses_imm=0. Without it: imm_src=0000, uses_imm=0.
- rst_n asserted mid-stream with both entries full → out_valid=0 and in_ready=1 without a clk edge.

Source files
------------

// File: rtl/id_stage_decode.sv
// id_stage_decode: instruction-decode pipeline stage feeding the immediate extender.
// Accepts fetched instructions over valid/ready, decodes the opcode class into the
// immediate-source selector and register indices, and holds up to two decoded
// words (main + skid) so in_ready never depends combinationally on out_ready.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high; valid-side data must be stable while valid is high, ready may change freely.
//
// Optional feature: define ID_STAGE_ILLEGAL_TRAP_EN to add the out_illegal port and
// flag opcode class 3'b111. Without it, class 3'b111 decodes exactly like class A.
module id_stage_decode #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32   // fixed at 32; other values are unsupported
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [25:0]        out_imm_in,
    output logic [3:0]         out_imm_src,
    output logic               out_uses_imm,
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
    output logic               out_illegal,
`endif
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2
);

    // One decoded instruction as held in either buffer entry.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [25:0]     imm_in;
        logic [3:0]      imm_src;
        logic            uses_imm;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } dec_t;

    // Opcode class lives in instr[31:29]; the "u" variant bit is instr[26].
    function automatic dec_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        dec_t d;
        logic u;
        u          = instr[26];
        d          = '0;
        d.pc       = pc;
        d.imm_in   = instr[25:0];
        d.rd       = instr[25:21];
        d.rs1      = instr[20:16];
        d.rs2      = instr[15:11];
        d.uses_imm = 1'b1;
        case (instr[31:29])
            3'b000: begin
                d.imm_src  = 4'b0000;
                d.uses_imm = 1'b0;
            end
            3'b001,
            3'b101: d.imm_src = {3'b000, u};
            3'b010: d.imm_src = {3'b010, u};
            3'b110: d.imm_src = {3'b100, u};
            3'b011: d.imm_src = {3'b110, u};
            3'b100: d.imm_src = 4'b0010;   // upper placement on the extender's default path
            default: begin
                // Class 3'b111: register-register shape, no immediate.
                d.imm_src  = 4'b0000;
                d.uses_imm = 1'b0;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
                d.illegal  = 1'b1;
`endif
            end
        endcase
        return d;
    endfunction

    logic main_valid;
    logic skid_valid;
    dec_t main_q;
    dec_t skid_q;
    dec_t dec_in;
    logic accept;
    logic deliver;

    assign dec_in  = decode(in_instr[31:0], in_pc);
    assign accept  = in_valid & in_ready;
    assign deliver = main_valid & out_ready;

    // Buffer control: flush wins, then deliver/refill, then plain capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (deliver) begin
            if (skid_valid) begin
                // in_ready is low while skid is full, so no accept can coincide here.
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= dec_in;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_q     <= dec_in;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec_in;
                skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready     = ~skid_valid;
    assign out_valid    = main_valid;
    assign out_pc       = main_q.pc;
    assign out_imm_in   = main_q.imm_in;
    assign out_imm_src  = main_q.imm_src;
    assign out_uses_imm = main_q.uses_imm;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
    assign out_illegal  = main_q.illegal;
`endif
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;

endmodule

// File: tb/tb_id_stage_decode.sv
// Bench for id_stage_decode: directed scenarios plus randomized traffic, with a
// scoreboard queue filled on every accepted instruction and drained on delivery.
module tb_id_stage_decode;

    localparam int PC_W = 32;
    localparam int W    = PC_W + 26 + 4 + 1 + 1 + 15;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [25:0]     out_imm_in;
    logic [3:0]      out_imm_src;
    logic            out_uses_imm;
    logic            dut_illegal;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;

    int errors = 0;
    int checks = 0;
    logic [PC_W-1:0] pc_cnt = 32'h1000;
    logic [W-1:0] exp_q[$];

    // Reference tables indexed by opcode class: upper selector bits, and whether
    // the u bit reaches the selector's LSB.
    logic [2:0] src_hi [0:7] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b001, 3'b000, 3'b100, 3'b000};
    logic       u_used [0:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    id_stage_decode #(.PC_W(PC_W), .INSTR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_imm_in   (out_imm_in),
        .out_imm_src  (out_imm_src),
        .out_uses_imm (out_uses_imm),
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
        .out_illegal  (dut_illegal),
`endif
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2)
    );

`ifndef ID_STAGE_ILLEGAL_TRAP_EN
    assign dut_illegal = 1'b0;
`endif

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        int   cls;
        logic u;
        logic [3:0] src;
        logic uses;
        logic ill;
        cls  = int'(instr[31:29]);
        u    = instr[26];
        src  = {src_hi[cls], u & u_used[cls]};
        uses = (cls != 0) && (cls != 7);
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
        ill  = (cls == 7);
`else
        ill  = 1'b0;
`endif
        return {pc, instr[25:0], src, uses, ill, instr[25:21], instr[20:16], instr[15:11]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard producer: every accepted instruction yields one expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready && !flush)
            exp_q.push_back(model(in_instr, in_pc));
    end

    // Monitor: compares each delivered word against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && flush) begin
            exp_q.delete();
        end else if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", {96'd0, out_pc}, 128'hdead);
            end else begin
                check("deliver", {out_pc, out_imm_in, out_imm_src, out_uses_imm, dut_illegal,
                                  out_rd, out_rs1, out_rs2}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] instr);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_cnt;
        @(negedge clk);
        while (!(in_ready && !flush) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pc_cnt   = pc_cnt + 4;
    endtask

    task automatic send_chk(input string name, input logic [31:0] instr,
                            input logic [3:0] src, input logic uses, input logic ill);
        out_ready = 1'b1;
        send(instr);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_src"}, out_imm_src, src);
        check({name, "_uses"}, out_uses_imm, uses);
        check({name, "_ill"}, dut_illegal, ill);
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fields", {out_pc, out_imm_in, out_imm_src, out_uses_imm, dut_illegal,
                             out_rd, out_rs1, out_rs2}, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single instruction latency and decode.
        out_ready = 1'b1;
        send(32'h2400_1234);
        check("first_valid", out_valid, 1);
        check("first_src", out_imm_src, 4'b0001);
        check("first_uses", out_uses_imm, 1);
        check("first_imm", out_imm_in, 26'h000_1234);
        drain();

        // Class coverage.
        send_chk("dupper", 32'h8000_0000, 4'b0010, 1'b1, 1'b0);
        send_chk("dlower_u", 32'h6400_0000, 4'b1101, 1'b1, 1'b0);
        send_chk("g_u0", 32'hC000_0000, 4'b1000, 1'b1, 1'b0);
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
        send_chk("illegal", 32'hE012_3456, 4'b0000, 1'b0, 1'b1);
`else
        send_chk("illegal", 32'hE012_3456, 4'b0000, 1'b0, 1'b0);
`endif
        drain();

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = $urandom;
            in_pc    = pc_cnt;
            pc_cnt   = pc_cnt + 4;
            @(negedge clk);
            check("stream_ready", in_ready, 1);
            if (i > 0) check("stream_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", out_valid, 1);
        drain();

        // Backpressure: third word stalls until the consumer releases.
        out_ready = 1'b0;
        send($urandom);
        send($urandom);
        in_valid = 1'b1;
        in_instr = $urandom;
        in_pc    = pc_cnt;
        @(negedge clk);
        check("bp_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(in_instr);
        drain();

        // Flush with both entries full and a word offered in the same cycle.
        out_ready = 1'b0;
        send($urandom);
        send($urandom);
        in_valid = 1'b1;
        in_instr = $urandom;
        in_pc    = 32'hBAD0_0000;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_ghost", out_valid, 0);

        // Asynchronous reset with both entries full.
        out_ready = 1'b0;
        send($urandom);
        send($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_ready", in_ready, 1);
        check("areset_pc", out_pc, 0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = $urandom;
            in_pc     = pc_cnt;
            pc_cnt    = pc_cnt + 4;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
